nbyn_traffic_pe: RTL and testbench
==================================

Name: nbyn_traffic_pe

Overview:
- Drop-in replacement for the processing element attached to the PE port of an nbyn switch inside a mesh tile.
- Injects a programmable burst of packets with round-robin destinations into the switch PE input.
- Sinks every packet the switch ejects to the PE port and checks that each one was addressed to this node.
- Exposes tx/rx counters, a sticky error flag and a done flag for mesh-level self-checking benches.

Parameters:
- x_coord, 'd0, this node's X coordinate
- y_coord, 'd0, this node's Y coordinate
- X_SIZE, 4, mesh columns; destination X range 0..X_SIZE-1
- Y_SIZE, 4, mesh rows; destination Y range 0..Y_SIZE-1
- NUM_PKTS, 16, packets injected per start; 1..65535
- GAP, 2, idle cycles between an accepted packet and the next o_valid; 0 allowed

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous active-low reset
- i_start  in  1  one-cycle pulse; starts a burst when idle or done
- i_data  in  `total_width  ejected packet from switch o_data_pe
- i_valid  in  1  from switch o_valid_pe
- i_ready  in  1  from switch o_ready_pe; switch accepts o_data this cycle
- o_data  out  `total_width  packet to switch i_data_pe
- o_valid  out  1  to switch i_valid_pe
- o_tx_count  out  16  packets accepted by switch this burst
- o_rx_count  out  16  packets received since reset
- o_err  out  1  sticky: misrouted packet received
- o_done  out  1  burst complete

Behaviour:
- Reset (rstn=0 at clk edge), regardless of state:
  - FSM goes to IDLE.
  - o_valid=0, o_data=0, o_tx_count=0, o_rx_count=0, o_err=0, o_done=0.
  - Destination pointer (dx,dy) is set to (0,0); seq is set to 0.
  - Reset mid-burst abandons the packet in flight; no completion is reported.
- Packet layout (field widths from include_file.v):
  - [`x_size-1:0] dest X
  - [`x_size+`y_size-1:`x_size] dest Y
  - remaining `data_width bits: payload = {x_coord, y_coord, seq}, zero-extended MSB side
  - seq is 16 bits and increments per accepted packet.
- FSM states: IDLE, LOAD, SEND, GAP, DONE.
  - IDLE: wait for i_start, then go to LOAD. Entering from DONE clears o_done, o_tx_count and seq.
  - DONE: i_start also goes to LOAD with the same clears.
  - LOAD (1 cycle): if (dx,dy)==(x_coord,y_coord), advance the pointer and stay in LOAD. Otherwise build o_data, set o_valid=1, go to SEND.
  - SEND: hold o_valid and o_data stable until i_ready=1. On that cycle (the transfer):
    - o_tx_count++, seq++, advance pointer.
    - If tx_count+1==NUM_PKTS: o_valid=0, o_done=1, go to DONE.
    - Else if GAP==0: go to LOAD.
    - Else: o_valid=0, go to GAP.
  - GAP: count GAP cycles, then go to LOAD.
- o_valid never drops without a transfer. Injection latency from i_start to first o_valid is 2 cycles minimum, plus one extra cycle per self-skip.
- Pointer advance: dx++; when dx==X_SIZE-1, dx wraps to 0 and dy++; when dy==Y_SIZE-1, dy wraps to 0.
- X_SIZE*Y_SIZE==1 is illegal; LOAD would loop forever. Implementation asserts on this in simulation.
- i_start outside IDLE/DONE is ignored.
- Sink side (independent of FSM, active in all states except reset):
  - Always ready; the switch's nbyn_pe interface has no PE ready toward the switch.
  - Each cycle i_valid=1: o_rx_count++, saturating at 16'hFFFF.
  - If the dest X/Y fields differ from (x_coord,y_coord), set o_err=1; cleared only by reset.
  - Simultaneous rx and tx in one cycle are both counted.
- o_tx_count and o_done are registered outputs.

Decomposition:
- Packet field macros (`x_size, `y_size, `data_width, `total_width) and field offset macros live in include_file.v. Add a `seq_width define there.
- One natural sub-module: nbyn_dest_gen, holding the (dx,dy) round-robin pointer with self-skip flag. Sink logic stays inline.

Test Plan:
- Reset mid-SEND: rstn=0 for 1 cycle with o_valid=1 -> next cycle o_valid=0, all counters 0, o_done=0, FSM IDLE.
- Node (1,1), 2x2 mesh, NUM_PKTS=4, GAP=0, i_ready tied 1 -> dests (0,0),(1,0),(0,1),(0,0); (1,1) is skipped. o_tx_count=4, o_done=1, seq payload 0..3.
- i_ready low for 5 cycles during SEND -> o_data and o_valid stable all 5 cycles; o_tx_count increments exactly once after i_ready rises.
- GAP=3 -> exactly 3 cycles of o_valid=0 between the transfer edge and the next LOAD, then o_valid rises 1 cycle later.
- Inject i_valid with dest (1,1) x10, then one with dest (0,1) -> o_rx_count=11, o_err=1 from the cycle after the bad packet. A second i_start does not clear o_err.
- i_start pulse while in DONE -> o_done=0, o_tx_count=0, seq restarts at 0, and a new burst completes with o_tx_count=NUM_PKTS.

Source files
------------

// File: rtl/nbyn_traffic_pe_pkg.sv
// Shared packet field layout, widths and FSM state type for the nbyn traffic PE.
// Field macros are guarded so another file can define the same layout without a clash.
`ifndef NBYN_PACKET_FIELDS
`define NBYN_PACKET_FIELDS
`define X_SIZE 2
`define Y_SIZE 2
`define DATA_WIDTH 32
`define SEQ_WIDTH 16
`define TOTAL_WIDTH (`X_SIZE + `Y_SIZE + `DATA_WIDTH)
`define X_LSB 0
`define Y_LSB `X_SIZE
`define DATA_LSB (`X_SIZE + `Y_SIZE)
`endif

package nbyn_traffic_pe_pkg;

  localparam int X_W     = `X_SIZE;
  localparam int Y_W     = `Y_SIZE;
  localparam int DATA_W  = `DATA_WIDTH;
  localparam int SEQ_W   = `SEQ_WIDTH;
  localparam int TOTAL_W = `TOTAL_WIDTH;
  localparam int Y_LSB   = `Y_LSB;
  localparam int D_LSB   = `DATA_LSB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } pe_state_t;

  // Payload is {src x, src y, seq}, zero-extended on the MSB side.
  function automatic logic [DATA_W-1:0] make_payload(input logic [X_W-1:0]   x,
                                                     input logic [Y_W-1:0]   y,
                                                     input logic [SEQ_W-1:0] seq);
    return DATA_W'({x, y, seq});
  endfunction

endpackage

// File: rtl/nbyn_traffic_pe_dest.sv
// Round-robin destination pointer over the mesh, flagging when it points at this node.
module nbyn_dest_gen
  import nbyn_traffic_pe_pkg::*;
#(
  parameter int X_SIZE  = 4,
  parameter int Y_SIZE  = 4,
  parameter int x_coord = 0,
  parameter int y_coord = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           advance,
  output logic [X_W-1:0] dx,
  output logic [Y_W-1:0] dy,
  output logic           is_self
);

  // A 1x1 mesh has no legal destination, so the self-skip would never terminate.
  if (X_SIZE * Y_SIZE == 1) begin : g_bad_mesh
    $error("nbyn_dest_gen: X_SIZE*Y_SIZE==1 leaves no destination other than this node");
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dx <= '0;
      dy <= '0;
    end else if (advance) begin
      if (dx == X_W'(X_SIZE - 1)) begin
        dx <= '0;
        dy <= (dy == Y_W'(Y_SIZE - 1)) ? '0 : dy + Y_W'(1);
      end else begin
        dx <= dx + X_W'(1);
      end
    end
  end

  assign is_self = (dx == X_W'(x_coord)) && (dy == Y_W'(y_coord));

endmodule

// File: rtl/nbyn_traffic_pe.sv
// Traffic-generating PE for an nbyn mesh tile: injects a burst of round-robin packets
// and sinks/validates every packet the switch ejects to this node.
module nbyn_traffic_pe
  import nbyn_traffic_pe_pkg::*;
#(
  parameter int x_coord  = 0,
  parameter int y_coord  = 0,
  parameter int X_SIZE   = 4,
  parameter int Y_SIZE   = 4,
  parameter int NUM_PKTS = 16,
  parameter int GAP      = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  logic [TOTAL_W-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_ready,
  output logic [TOTAL_W-1:0] o_data,
  output logic               o_valid,
  output logic [15:0]        o_tx_count,
  output logic [15:0]        o_rx_count,
  output logic               o_err,
  output logic               o_done
);

  pe_state_t          state, state_n;
  logic [SEQ_W-1:0]   seq, seq_n;
  logic [15:0]        gap_cnt, gap_cnt_n;
  logic [15:0]        tx_count_n;
  logic [TOTAL_W-1:0] data_n;
  logic               valid_n, done_n, advance;
  logic [X_W-1:0]     dx;
  logic [Y_W-1:0]     dy;
  logic               is_self;

  nbyn_dest_gen #(
    .X_SIZE  (X_SIZE),
    .Y_SIZE  (Y_SIZE),
    .x_coord (x_coord),
    .y_coord (y_coord)
  ) u_dest (
    .clk     (clk),
    .rstn    (rstn),
    .advance (advance),
    .dx      (dx),
    .dy      (dy),
    .is_self (is_self)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      seq        <= '0;
      gap_cnt    <= '0;
      o_tx_count <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_n;
      seq        <= seq_n;
      gap_cnt    <= gap_cnt_n;
      o_tx_count <= tx_count_n;
      o_data     <= data_n;
      o_valid    <= valid_n;
      o_done     <= done_n;
    end
  end

  // o_valid is dropped on every transfer, so a stale packet is never offered twice.
  always_comb begin
    state_n    = state;
    seq_n      = seq;
    gap_cnt_n  = gap_cnt;
    tx_count_n = o_tx_count;
    data_n     = o_data;
    valid_n    = o_valid;
    done_n     = o_done;
    advance    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_n    = S_LOAD;
          done_n     = 1'b0;
          tx_count_n = '0;
          seq_n      = '0;
        end
      end
      S_LOAD: begin
        if (is_self) begin
          advance = 1'b1;
        end else begin
          data_n  = {make_payload(X_W'(x_coord), Y_W'(y_coord), seq), dy, dx};
          valid_n = 1'b1;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (i_ready) begin
          tx_count_n = o_tx_count + 16'd1;
          seq_n      = seq + SEQ_W'(1);
          advance    = 1'b1;
          valid_n    = 1'b0;
          gap_cnt_n  = '0;
          if (o_tx_count == 16'(NUM_PKTS - 1)) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else if (GAP == 0) begin
            state_n = S_LOAD;
          end else begin
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == 16'(GAP - 1)) begin
          state_n = S_LOAD;
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  logic unused_rx_payload;
  assign unused_rx_payload = ^i_data[TOTAL_W-1:D_LSB];

  // The switch has no PE-side backpressure, so the sink accepts every valid cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_rx_count <= '0;
      o_err      <= 1'b0;
    end else if (i_valid) begin
      if (o_rx_count != 16'hFFFF) begin
        o_rx_count <= o_rx_count + 16'd1;
      end
      if ((i_data[X_W-1:0] != X_W'(x_coord)) ||
          (i_data[Y_LSB+Y_W-1:Y_LSB] != Y_W'(y_coord))) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nbyn_traffic_pe.sv
// Scoreboard bench for nbyn_traffic_pe at node (1,1) of a 2x2 mesh, plus a GAP=3 instance.
module tb_nbyn_traffic_pe;
  import nbyn_traffic_pe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn, i_start, i_valid, i_ready;
  logic [TOTAL_W-1:0] i_data, o_data;
  logic               o_valid, o_err, o_done;
  logic [15:0]        o_tx_count, o_rx_count;

  logic               g_start;
  logic [TOTAL_W-1:0] g_data;
  logic               g_valid, g_err, g_done;
  logic [15:0]        g_tx_count, g_rx_count;

  int checks = 0;
  int errors = 0;
  logic [TOTAL_W-1:0] exp_q[$];

  // {payload 0x50000+seq, dy, dx} for node (1,1); (1,1) itself is skipped.
  localparam logic [TOTAL_W-1:0] BURST_A [4] = '{36'h0_0050_0000, 36'h0_0050_0011,
                                                 36'h0_0050_0024, 36'h0_0050_0030};
  localparam logic [TOTAL_W-1:0] BURST_B [4] = '{36'h0_0050_0001, 36'h0_0050_0014,
                                                 36'h0_0050_0020, 36'h0_0050_0031};

  nbyn_traffic_pe #(
    .x_coord(1), .y_coord(1), .X_SIZE(2), .Y_SIZE(2), .NUM_PKTS(4), .GAP(0)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_data(i_data), .i_valid(i_valid),
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_tx_count(o_tx_count),
    .o_rx_count(o_rx_count), .o_err(o_err), .o_done(o_done)
  );

  nbyn_traffic_pe #(
    .x_coord(1), .y_coord(1), .X_SIZE(2), .Y_SIZE(2), .NUM_PKTS(4), .GAP(3)
  ) dut_gap (
    .clk(clk), .rstn(rstn), .i_start(g_start), .i_data('0), .i_valid(1'b0),
    .i_ready(1'b1), .o_data(g_data), .o_valid(g_valid), .o_tx_count(g_tx_count),
    .o_rx_count(g_rx_count), .o_err(g_err), .o_done(g_done)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int n = 0; n < 100 && !o_done; n++) tick();
    checkOutput({name, "_done"}, 64'(o_done), 64'd1);
  endtask

  task automatic applyStimulus(input logic [TOTAL_W-1:0] pkt);
    i_valid = 1'b1;
    i_data  = pkt;
    tick();
    i_valid = 1'b0;
    i_data  = '0;
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rstn && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pkt actual=%0h expected=none", o_data);
      end else begin
        checkOutput("pkt", 64'(o_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int lows;
    rstn = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1; g_start = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_data", 64'(o_data), 64'd0);
    checkOutput("rst_tx", 64'(o_tx_count), 64'd0);
    checkOutput("rst_rx", 64'(o_rx_count), 64'd0);
    checkOutput("rst_err", 64'(o_err), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);

    $display("[TB] burst A, ready tied high");
    for (int i = 0; i < 4; i++) exp_q.push_back(BURST_A[i]);
    pulseStart();
    checkOutput("latency_load", 64'(o_valid), 64'd0);
    tick();
    checkOutput("latency_send", 64'(o_valid), 64'd1);
    waitDone("burst_a");
    checkOutput("burst_a_tx", 64'(o_tx_count), 64'd4);
    checkOutput("burst_a_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] sink: 10 good packets then one misrouted");
    for (int i = 0; i < 10; i++) applyStimulus(36'h5);
    checkOutput("sink_rx10", 64'(o_rx_count), 64'd10);
    checkOutput("sink_err_clean", 64'(o_err), 64'd0);
    applyStimulus(36'h4);
    checkOutput("sink_rx11", 64'(o_rx_count), 64'd11);
    checkOutput("sink_err_set", 64'(o_err), 64'd1);

    $display("[TB] burst B restarted from DONE with a 5-cycle stall");
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(BURST_B[i]);
    pulseStart();
    checkOutput("restart_done_clr", 64'(o_done), 64'd0);
    checkOutput("restart_tx_clr", 64'(o_tx_count), 64'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_valid", 64'(o_valid), 64'd1);
      checkOutput("stall_data", 64'(o_data), 64'(BURST_B[0]));
      checkOutput("stall_tx", 64'(o_tx_count), 64'd0);
      tick();
    end
    i_ready = 1'b1;
    tick();
    checkOutput("stall_tx_once", 64'(o_tx_count), 64'd1);
    waitDone("burst_b");
    checkOutput("burst_b_tx", 64'(o_tx_count), 64'd4);
    checkOutput("burst_b_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("err_sticky", 64'(o_err), 64'd1);

    $display("[TB] reset in the middle of SEND");
    i_ready = 1'b0;
    pulseStart();
    tick();
    checkOutput("pre_rst_valid", 64'(o_valid), 64'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkOutput("midrst_valid", 64'(o_valid), 64'd0);
    checkOutput("midrst_tx", 64'(o_tx_count), 64'd0);
    checkOutput("midrst_rx", 64'(o_rx_count), 64'd0);
    checkOutput("midrst_err", 64'(o_err), 64'd0);
    checkOutput("midrst_done", 64'(o_done), 64'd0);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(BURST_A[i]);
    pulseStart();
    waitDone("burst_c");
    checkOutput("burst_c_tx", 64'(o_tx_count), 64'd4);
    checkOutput("burst_c_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] GAP=3 spacing");
    g_start = 1'b1;
    tick();
    g_start = 1'b0;
    for (int n = 0; n < 20 && !g_valid; n++) tick();
    checkOutput("gap_first_valid", 64'(g_valid), 64'd1);
    checkOutput("gap_first_data", 64'(g_data), 64'(BURST_A[0]));
    tick();
    lows = 0;
    while (!g_valid && lows < 20) begin
      lows++;
      tick();
    end
    checkOutput("gap_low_cycles", 64'(lows), 64'd4);
    checkOutput("gap_tx", 64'(g_tx_count), 64'd1);
    checkOutput("gap_second_data", 64'(g_data), 64'(BURST_A[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
